// File: rtl/apu_bus_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apu_bus_pkg
//  Description : Shared types and constants for the SNES APU bus bridge:
//                FSM state encoding, parameter defaults and the phase
//                counter width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package apu_bus_pkg;

    localparam int ADDR_W_DEF     = 2;
    localparam int DATA_W_DEF     = 8;
    localparam int SETUP_CYC_DEF  = 2;
    localparam int STROBE_CYC_DEF = 4;
    localparam int HOLD_CYC_DEF   = 2;
    localparam int CLK_DIV_DEF    = 2;
    localparam int RST_CYC_DEF    = 64;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_RST    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4
    } apu_bus_state_t;

    // Width of a down-counter that must hold (largest phase length - 1).
    // Never returns less than one bit so degenerate parameter sets still build.
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apu_bus_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : apu_bus_bridge_if
//  Description : Core-side request/response handshake plus APU pin bundle.
//                The bridge uses the master modport; the core/board side
//                (or a bench) uses the slave modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface apu_bus_bridge_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 8
) ();
    // core-side handshake
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    // APU pins
    logic              APU_RSTn;
    logic              APU_CLK;
    logic              APU_WEn;
    logic              APU_RDn;
    logic              APU_DEn;
    logic [ADDR_W-1:0] APU_A;
    logic [DATA_W-1:0] APU_Dout;
    logic [DATA_W-1:0] APU_Din;

    modport master (
        input  req, we, addr, wdata, APU_Din,
        output busy, ack, rdata,
        output APU_RSTn, APU_CLK, APU_WEn, APU_RDn, APU_DEn, APU_A, APU_Dout
    );

    modport slave (
        output req, we, addr, wdata, APU_Din,
        input  busy, ack, rdata,
        input  APU_RSTn, APU_CLK, APU_WEn, APU_RDn, APU_DEn, APU_A, APU_Dout
    );
endinterface
`default_nettype wire

// File: rtl/apu_bus_bridge_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : apu_clk_div
//  Description : Free-running APU clock divider; output toggles every
//                CLK_DIV system clocks. Only p_reset stops/clears it.
//  Revision    : 1.0  initial release
// ============================================================================
module apu_clk_div
    import apu_bus_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic m_clock,
    input  logic p_reset,
    output logic apu_clk
);
    localparam int             DIV_W    = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_cnt;
    logic             r_clk;

    // Count CLK_DIV cycles per half period, toggling on the last one.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            r_cnt <= '0;
            r_clk <= 1'b0;
        end else if (r_cnt == DIV_LAST) begin
            r_cnt <= '0;
            r_clk <= ~r_clk;
        end else begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    assign apu_clk = r_clk;
endmodule
`default_nettype wire

// File: rtl/apu_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : apu_bus_bridge
//  Description : Timed, handshaked bus master for the external SPC700 APU
//                board. Sequences APU reset, runs setup/strobe/hold cycles
//                and generates the free-running APU clock.
//                Optional macro APU_BRIDGE_POST_EN enables a one-entry
//                posted-write buffer (writes acked right after acceptance).
//  Revision    : 1.0  initial release
// ============================================================================
module apu_bus_bridge
    import apu_bus_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int SETUP_CYC  = SETUP_CYC_DEF,
    parameter int STROBE_CYC = STROBE_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int CLK_DIV    = CLK_DIV_DEF,
    parameter int RST_CYC    = RST_CYC_DEF
) (
    input  logic             m_clock,
    input  logic             p_reset,
    input  logic             soft_rst,
    apu_bus_bridge_if.master bus
);
    localparam int               CNT_W     = cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC, RST_CYC);
    localparam logic [CNT_W-1:0] LD_RST    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);

    apu_bus_state_t    r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_ld;
    logic              w_cnt_done;

    logic              r_we;          // direction of the cycle on the bus
    logic [DATA_W-1:0] r_din_cap;     // APU_Din sampled on the last strobe cycle

    logic              r_busy, r_ack, r_rstn, r_wen, r_rdn, r_den;
    logic [ADDR_W-1:0] r_apu_a;
    logic [DATA_W-1:0] r_dout, r_rdata;

    logic              w_busy_d, w_ack_d, w_rstn_d, w_wen_d, w_rdn_d, w_den_d;
    logic              w_accept, w_launch, w_done_cycle, w_in_cycle, w_we_nxt;
    logic              w_l_we;
    logic [ADDR_W-1:0] w_l_addr;
    logic [DATA_W-1:0] w_l_wdata;

    assign w_cnt_done   = (r_cnt == '0);
    // soft_rst always wins over a new request
    assign w_accept     = bus.req && !r_busy && !soft_rst;
    assign w_done_cycle = (r_state == ST_HOLD) && w_cnt_done && !soft_rst;

`ifdef APU_BRIDGE_POST_EN
    logic              r_buf_vld, r_buf_we;
    logic [ADDR_W-1:0] r_buf_addr;
    logic [DATA_W-1:0] r_buf_wdata;
    logic              w_buf_push, w_buf_pop, w_buf_vld_nxt;

    // Launch source: a buffered request has priority over a fresh one.
    always_comb begin
        w_launch  = 1'b0;
        w_buf_pop = 1'b0;
        w_l_we    = bus.we;
        w_l_addr  = bus.addr;
        w_l_wdata = bus.wdata;
        if (r_state == ST_IDLE && !soft_rst) begin
            if (r_buf_vld) begin
                w_launch  = 1'b1;
                w_buf_pop = 1'b1;
                w_l_we    = r_buf_we;
                w_l_addr  = r_buf_addr;
                w_l_wdata = r_buf_wdata;
            end else if (w_accept) begin
                w_launch  = 1'b1;
            end
        end
        w_buf_push    = w_accept && !(w_launch && !w_buf_pop);
        w_buf_vld_nxt = !soft_rst && (w_buf_push || (r_buf_vld && !w_buf_pop));
    end

    // One-entry buffer; soft_rst discards whatever it holds.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            r_buf_vld   <= 1'b0;
            r_buf_we    <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_wdata <= '0;
        end else begin
            r_buf_vld <= w_buf_vld_nxt;
            if (w_buf_push) begin
                r_buf_we    <= bus.we;
                r_buf_addr  <= bus.addr;
                r_buf_wdata <= bus.wdata;
            end
        end
    end
`else
    // Without posting, a cycle starts only straight from an idle accept.
    always_comb begin
        w_launch  = (r_state == ST_IDLE) && w_accept;
        w_l_we    = bus.we;
        w_l_addr  = bus.addr;
        w_l_wdata = bus.wdata;
    end
`endif

    // State register and phase counter; the counter reloads on every entry.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            r_state <= ST_RST;
            r_cnt   <= LD_RST;
        end else begin
            r_state <= w_state_nxt;
            if (soft_rst || (w_state_nxt != r_state))
                r_cnt <= w_cnt_ld;
            else if (!w_cnt_done)
                r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Next-state selection and the phase length of the state being entered.
    always_comb begin
        w_state_nxt = r_state;
        if (soft_rst) begin
            w_state_nxt = ST_RST;
        end else begin
            case (r_state)
                ST_RST:    if (w_cnt_done) w_state_nxt = ST_IDLE;
                ST_IDLE:   if (w_launch)   w_state_nxt = ST_SETUP;
                ST_SETUP:  if (w_cnt_done) w_state_nxt = ST_STROBE;
                ST_STROBE: if (w_cnt_done) w_state_nxt = ST_HOLD;
                ST_HOLD:   if (w_cnt_done) w_state_nxt = ST_IDLE;
                default:                   w_state_nxt = ST_RST;
            endcase
        end
        case (w_state_nxt)
            ST_RST:    w_cnt_ld = LD_RST;
            ST_SETUP:  w_cnt_ld = LD_SETUP;
            ST_STROBE: w_cnt_ld = LD_STROBE;
            ST_HOLD:   w_cnt_ld = LD_HOLD;
            default:   w_cnt_ld = '0;
        endcase
    end

    // Pin/handshake values for the next cycle, derived from the next state.
    always_comb begin
        w_we_nxt   = w_launch ? w_l_we : r_we;
        w_in_cycle = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE) ||
                     (w_state_nxt == ST_HOLD);
        w_rstn_d   = (w_state_nxt != ST_RST);
        w_wen_d    = !((w_state_nxt == ST_STROBE) &&  w_we_nxt);
        w_rdn_d    = !((w_state_nxt == ST_STROBE) && !w_we_nxt);
        w_den_d    = !(w_in_cycle && w_we_nxt);
`ifdef APU_BRIDGE_POST_EN
        w_busy_d   = (w_state_nxt == ST_RST) || w_buf_vld_nxt || (w_in_cycle && !w_we_nxt);
        w_ack_d    = (w_accept && bus.we) || (w_done_cycle && !r_we);
`else
        w_busy_d   = (w_state_nxt != ST_IDLE);
        w_ack_d    = w_done_cycle;
`endif
    end

    // Registered outputs, launch latch and read-data capture.
    always_ff @(posedge m_clock) begin
        if (p_reset) begin
            r_rstn    <= 1'b0;
            r_wen     <= 1'b1;
            r_rdn     <= 1'b1;
            r_den     <= 1'b1;
            r_busy    <= 1'b1;
            r_ack     <= 1'b0;
            r_apu_a   <= '0;
            r_dout    <= '0;
            r_rdata   <= '0;
            r_we      <= 1'b0;
            r_din_cap <= '0;
        end else begin
            r_rstn <= w_rstn_d;
            r_wen  <= w_wen_d;
            r_rdn  <= w_rdn_d;
            r_den  <= w_den_d;
            r_busy <= w_busy_d;
            r_ack  <= w_ack_d;
            if (w_launch) begin
                r_we    <= w_l_we;
                r_apu_a <= w_l_addr;
                r_dout  <= w_l_wdata;
            end
            if ((r_state == ST_STROBE) && w_cnt_done && !r_we)
                r_din_cap <= bus.APU_Din;
            if (w_done_cycle && !r_we)
                r_rdata <= r_din_cap;
        end
    end

    apu_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .m_clock (m_clock),
        .p_reset (p_reset),
        .apu_clk (bus.APU_CLK)
    );

    assign bus.APU_RSTn = r_rstn;
    assign bus.APU_WEn  = r_wen;
    assign bus.APU_RDn  = r_rdn;
    assign bus.APU_DEn  = r_den;
    assign bus.APU_A    = r_apu_a;
    assign bus.APU_Dout = r_dout;
    assign bus.busy     = r_busy;
    assign bus.ack      = r_ack;
    assign bus.rdata    = r_rdata;
endmodule
`default_nettype wire
